vrf_req_arbiter: RTL and testbench

//  Shares one vregfile_wrapper (single-port VRF sequencer) between NumReq vector requesters,
//  e.g. the vector execute stage and the vector load/store unit.

---
 rtl/vrf_req_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_vrf_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_req_arbiter.sv
// Round-robin arbiter sharing one single-port VRF sequencer between NumReq vector requesters.
// Optional per-requester completed-grant counters are enabled with `define VRF_ARB_STATS_EN.

module vrf_arb_slot (
`ifdef VRF_ARB_STATS_EN
   input  logic        clk_i,
   input  logic        rst_ni,
`endif
   input  logic        gnt_i,
   input  logic        busy_i,
   input  logic        vrf_done_i,
`ifdef VRF_ARB_STATS_EN
   output logic [15:0] grant_cnt_o,
`endif
   output logic        done_o
);

   assign done_o = gnt_i & busy_i & vrf_done_i;

`ifdef VRF_ARB_STATS_EN
   // Saturating count of completed grants.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         grant_cnt_o <= '0;
      else if (done_o && (grant_cnt_o != 16'hFFFF))
         grant_cnt_o <= grant_cnt_o + 16'd1;
   end
`endif

endmodule

module vrf_req_arbiter #(
   parameter int NumReq    = 2,
   parameter int ELEN      = 32,
   parameter int AddrWidth = 5
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*AddrWidth-1:0]   raddr_a_i,
   input  logic [NumReq*AddrWidth-1:0]   raddr_b_i,
   input  logic [NumReq*AddrWidth-1:0]   waddr_i,
   input  logic [NumReq*ELEN-1:0]        wdata_i,
   input  logic [NumReq*2-1:0]           num_ops_i,
   input  logic [NumReq*3-1:0]           lmul_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             done_o,
   output logic [ELEN-1:0]               rdata_a_o,
   output logic [ELEN-1:0]               rdata_b_o,
   output logic [ELEN-1:0]               rdata_c_o,
   output logic                          vrf_req_o,
   output logic                          vrf_we_o,
   output logic [AddrWidth-1:0]          vrf_raddr_a_o,
   output logic [AddrWidth-1:0]          vrf_raddr_b_o,
   output logic [AddrWidth-1:0]          vrf_waddr_o,
   output logic [ELEN-1:0]               vrf_wdata_o,
   output logic [1:0]                    vrf_num_ops_o,
   output logic [2:0]                    vrf_lmul_o,
   input  logic [ELEN-1:0]               vrf_rdata_a_i,
   input  logic [ELEN-1:0]               vrf_rdata_b_i,
   input  logic [ELEN-1:0]               vrf_rdata_c_i,
   input  logic                          vrf_done_i
`ifdef VRF_ARB_STATS_EN
   ,
   output logic [NumReq*16-1:0]          grant_cnt_o
`endif
);

   localparam int RrW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

   arb_state_e        state_q, state_d;
   logic [NumReq-1:0] gnt_q, gnt_d;
   logic [RrW-1:0]    rr_q, rr_d;
   logic [RrW-1:0]    own_q, own_d;
   logic [RrW-1:0]    win_idx;
   logic              win_vld;
   logic              busy;

   logic [NumReq-1:0][AddrWidth-1:0] raddr_a, raddr_b, waddr;
   logic [NumReq-1:0][ELEN-1:0]      wdata;
   logic [NumReq-1:0][1:0]           num_ops;
   logic [NumReq-1:0][2:0]           lmul;

   assign raddr_a = raddr_a_i;
   assign raddr_b = raddr_b_i;
   assign waddr   = waddr_i;
   assign wdata   = wdata_i;
   assign num_ops = num_ops_i;
   assign lmul    = lmul_i;

   assign busy = (state_q == ARB_BUSY);

   // Scan from the highest offset down so the requester closest to rr_q wins.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NumReq;
         if (req_i[idx]) begin
            win_vld = 1'b1;
            win_idx = RrW'(idx);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         own_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         own_q   <= own_d;
      end
   end

   always_comb begin
      int nxt;
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      own_d   = own_q;
      nxt     = 0;
      case (state_q)
         ARB_IDLE: begin
            if (win_vld) begin
               nxt = int'(win_idx) + 1;
               if (nxt >= NumReq) nxt = 0;
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               own_d          = win_idx;
               rr_d           = RrW'(nxt);
               state_d        = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // Ownership holds across every register of the group; only the
            // wrapper's final done releases it, always via one idle cycle.
            if (vrf_done_i) begin
               gnt_d   = '0;
               state_d = ARB_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_comb begin
      vrf_we_o      = 1'b0;
      vrf_raddr_a_o = '0;
      vrf_raddr_b_o = '0;
      vrf_waddr_o   = '0;
      vrf_wdata_o   = '0;
      vrf_num_ops_o = '0;
      vrf_lmul_o    = '0;
      if (busy) begin
         vrf_we_o      = we_i[own_q];
         vrf_raddr_a_o = raddr_a[own_q];
         vrf_raddr_b_o = raddr_b[own_q];
         vrf_waddr_o   = waddr[own_q];
         vrf_wdata_o   = wdata[own_q];
         vrf_num_ops_o = num_ops[own_q];
         vrf_lmul_o    = lmul[own_q];
      end
   end

   assign vrf_req_o = busy;
   assign gnt_o     = gnt_q;
   assign rdata_a_o = vrf_rdata_a_i;
   assign rdata_b_o = vrf_rdata_b_i;
   assign rdata_c_o = vrf_rdata_c_i;

   for (genvar g = 0; g < NumReq; g++) begin : g_slot
      vrf_arb_slot u_slot (
`ifdef VRF_ARB_STATS_EN
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
`endif
         .gnt_i       (gnt_q[g]),
         .busy_i      (busy),
         .vrf_done_i  (vrf_done_i),
`ifdef VRF_ARB_STATS_EN
         .grant_cnt_o (grant_cnt_o[g*16 +: 16]),
`endif
         .done_o      (done_o[g])
      );
   end

endmodule

// File: tb/tb_vrf_req_arbiter.sv
// Scoreboard bench for vrf_req_arbiter with a behavioural VRF wrapper model.
// Directed operations push expected grants; a monitor checks each done_o pulse.

module tb_vrf_req_arbiter;

   localparam int NR = 2;
   localparam int EL = 32;
   localparam int AW = 5;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b1;
   logic [NR-1:0]     req_i = '0;
   logic [NR-1:0]     we_i = '0;
   logic [NR*AW-1:0]  raddr_a_i = '0;
   logic [NR*AW-1:0]  raddr_b_i = '0;
   logic [NR*AW-1:0]  waddr_i = '0;
   logic [NR*EL-1:0]  wdata_i = '0;
   logic [NR*2-1:0]   num_ops_i = '0;
   logic [NR*3-1:0]   lmul_i = '0;
   logic [NR-1:0]     gnt_o, done_o;
   logic [EL-1:0]     rdata_a_o, rdata_b_o, rdata_c_o;
   logic              vrf_req_o, vrf_we_o;
   logic [AW-1:0]     vrf_raddr_a_o, vrf_raddr_b_o, vrf_waddr_o;
   logic [EL-1:0]     vrf_wdata_o;
   logic [1:0]        vrf_num_ops_o;
   logic [2:0]        vrf_lmul_o;
   logic [EL-1:0]     vrf_rdata_a_i = '0, vrf_rdata_b_i = '0, vrf_rdata_c_i = '0;
   logic              vrf_done_i = 1'b0;
`ifdef VRF_ARB_STATS_EN
   logic [NR*16-1:0]  grant_cnt_o;
`endif

   vrf_req_arbiter #(.NumReq(NR), .ELEN(EL), .AddrWidth(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .waddr_i(waddr_i),
      .wdata_i(wdata_i), .num_ops_i(num_ops_i), .lmul_i(lmul_i),
      .gnt_o(gnt_o), .done_o(done_o),
      .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o), .rdata_c_o(rdata_c_o),
      .vrf_req_o(vrf_req_o), .vrf_we_o(vrf_we_o),
      .vrf_raddr_a_o(vrf_raddr_a_o), .vrf_raddr_b_o(vrf_raddr_b_o),
      .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
      .vrf_num_ops_o(vrf_num_ops_o), .vrf_lmul_o(vrf_lmul_o),
      .vrf_rdata_a_i(vrf_rdata_a_i), .vrf_rdata_b_i(vrf_rdata_b_i),
      .vrf_rdata_c_i(vrf_rdata_c_i), .vrf_done_i(vrf_done_i)
`ifdef VRF_ARB_STATS_EN
      , .grant_cnt_o(grant_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          idx;
      logic        we;
      logic [4:0]  ra, rb, wa;
      logic [31:0] wd;
      logic [1:0]  nops;
      logic [2:0]  lmul;
   } op_t;

   op_t cfg [NR];
   op_t exp_q [$];
   int  rem [NR];
   int  n_chk = 0;
   int  n_fail = 0;
   logic force_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Wrapper spends two cycles per group register: LMUL 1/2/4/8 -> 2/4/8/16 cycles.
   function automatic int busy_cycles(input logic [2:0] lmul);
      case (lmul)
         3'd1:    return 4;
         3'd2:    return 8;
         3'd3:    return 16;
         default: return 2;
      endcase
   endfunction

   // Behavioural wrapper: counts cycles with vrf_req_o high and pulses done.
   initial begin : wrapper_model
      int mcnt;
      mcnt = 0;
      forever begin
         @(negedge clk_i);
         vrf_rdata_a_i = 32'hA5A5_0000 | {27'd0, vrf_raddr_a_o};
         vrf_rdata_b_i = 32'h5A5A_0000 | {27'd0, vrf_raddr_b_o};
         vrf_rdata_c_i = 32'hC3C3_0000 | {27'd0, vrf_waddr_o};
         if (!rst_ni || !vrf_req_o) begin
            mcnt = 0;
            vrf_done_i = force_done;
         end else begin
            mcnt++;
            if (mcnt == busy_cycles(vrf_lmul_o)) begin
               vrf_done_i = 1'b1;
               mcnt = 0;
            end else begin
               vrf_done_i = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every done_o pulse.
   initial begin : monitor
      int   busy_cnt;
      logic after_done;
      logic [1:0] oh;
      op_t  e;
      busy_cnt = 0;
      after_done = 1'b0;
      forever begin
         @(negedge clk_i);
         #1;
         if (!rst_ni) begin
            busy_cnt = 0;
            after_done = 1'b0;
            continue;
         end
         if (after_done) begin
            chk("idle_gap_gnt", 64'(gnt_o), 64'd0);
            chk("idle_gap_req", 64'(vrf_req_o), 64'd0);
            after_done = 1'b0;
         end
         if (vrf_req_o) busy_cnt++;
         if (done_o != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(done_o), 64'd0);
            end else begin
               e  = exp_q.pop_front();
               oh = 2'b01 << e.idx;
               chk("done_onehot", 64'(done_o), 64'(oh));
               chk("gnt_owner", 64'(gnt_o), 64'(oh));
               chk("vrf_we", 64'(vrf_we_o), 64'(e.we));
               chk("vrf_raddr_a", 64'(vrf_raddr_a_o), 64'(e.ra));
               chk("vrf_raddr_b", 64'(vrf_raddr_b_o), 64'(e.rb));
               chk("vrf_waddr", 64'(vrf_waddr_o), 64'(e.wa));
               chk("vrf_wdata", 64'(vrf_wdata_o), 64'(e.wd));
               chk("vrf_num_ops", 64'(vrf_num_ops_o), 64'(e.nops));
               chk("vrf_lmul", 64'(vrf_lmul_o), 64'(e.lmul));
               chk("req_held_cycles", 64'(busy_cnt), 64'(busy_cycles(e.lmul)));
               chk("rdata_a", 64'(rdata_a_o), 64'(32'hA5A5_0000 | {27'd0, e.ra}));
               chk("rdata_b", 64'(rdata_b_o), 64'(32'h5A5A_0000 | {27'd0, e.rb}));
               chk("rdata_c", 64'(rdata_c_o), 64'(32'hC3C3_0000 | {27'd0, e.wa}));
            end
            busy_cnt = 0;
            after_done = 1'b1;
         end
      end
   end

   task automatic issue(input int i, input int n, input logic [2:0] lmul,
                        input logic [1:0] nops, input logic [4:0] wa, input logic [31:0] wd);
      cfg[i].idx  = i;
      cfg[i].we   = wd[0];
      cfg[i].ra   = wa + 5'd1;
      cfg[i].rb   = wa + 5'd2;
      cfg[i].wa   = wa;
      cfg[i].wd   = wd;
      cfg[i].nops = nops;
      cfg[i].lmul = lmul;
      we_i[i]              = cfg[i].we;
      raddr_a_i[i*AW +: AW] = cfg[i].ra;
      raddr_b_i[i*AW +: AW] = cfg[i].rb;
      waddr_i[i*AW +: AW]   = wa;
      wdata_i[i*EL +: EL]   = wd;
      num_ops_i[i*2 +: 2]   = nops;
      lmul_i[i*3 +: 3]      = lmul;
      rem[i]   = n;
      req_i[i] = 1'b1;
   endtask

   task automatic expect_op(input int i);
      exp_q.push_back(cfg[i]);
   endtask

   // Requesters drop req_i once their last operation's done_o is seen.
   task automatic run_ops(input string name);
      int t;
      t = 0;
      while ((rem[0] != 0 || rem[1] != 0) && t < 400) begin
         @(negedge clk_i);
         #2;
         t++;
         for (int i = 0; i < NR; i++)
            if (done_o[i] && rem[i] > 0) begin
               rem[i]--;
               if (rem[i] == 0) req_i[i] = 1'b0;
            end
      end
      chk(name, 64'(rem[0] + rem[1]), 64'd0);
      repeat (2) @(negedge clk_i);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      #2;
      rst_ni = 1'b1;
   endtask

   initial begin
      rem[0] = 0;
      rem[1] = 0;
      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_vrf_req", 64'(vrf_req_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_vrf_waddr", 64'(vrf_waddr_o), 64'd0);
      #2 rst_ni = 1'b1;
      @(negedge clk_i);
      #2;

      // Single requester, LMUL_1, two operands; grant one cycle after request.
      issue(0, 1, 3'd0, 2'd2, 5'd3, 32'h1111_0001);
      expect_op(0);
      #1 chk("gnt_before_edge", 64'(gnt_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("gnt_latency", 64'(gnt_o), 64'd1);
      chk("vrf_req_on_grant", 64'(vrf_req_o), 64'd1);
      run_ops("single_req0_timeout");

      // Done from the wrapper while idle is ignored.
      force_done = 1'b1;
      @(negedge clk_i);
      #2;
      chk("idle_done_ignored", 64'(done_o), 64'd0);
      force_done = 1'b0;
      @(posedge clk_i);
      #1 chk("idle_stays_idle", 64'(gnt_o), 64'd0);

      // Simultaneous requests from reset: req0 then req1.
      do_reset();
      issue(0, 1, 3'd0, 2'd1, 5'd8, 32'h2222_0002);
      issue(1, 1, 3'd1, 2'd3, 5'd12, 32'h3333_0003);
      expect_op(0);
      expect_op(1);
      run_ops("simultaneous_timeout");

      // LMUL_4 on req1: one grant across four group registers.
      issue(1, 1, 3'd2, 2'd3, 5'd16, 32'h4444_0005);
      expect_op(1);
      run_ops("lmul4_timeout");

      // Sole requester regranted after the idle cycle.
      issue(0, 2, 3'd0, 2'd0, 5'd20, 32'h5555_0006);
      expect_op(0);
      expect_op(0);
      run_ops("regrant_timeout");

      // Dropping req_i while granted still completes.
      issue(1, 1, 3'd1, 2'd2, 5'd24, 32'h6666_0007);
      expect_op(1);
      @(posedge clk_i);
      #1 req_i[1] = 1'b0;
      run_ops("drop_req_timeout");

      // Both held for six operations: strict alternation.
      do_reset();
      issue(0, 3, 3'd0, 2'd2, 5'd1, 32'h7777_0008);
      issue(1, 3, 3'd0, 2'd1, 5'd9, 32'h8888_0009);
      for (int k = 0; k < 3; k++) begin
         expect_op(0);
         expect_op(1);
      end
      run_ops("alternate_timeout");
`ifdef VRF_ARB_STATS_EN
      chk("stats_cnt0", 64'(grant_cnt_o[15:0]), 64'd3);
      chk("stats_cnt1", 64'(grant_cnt_o[31:16]), 64'd3);
`endif

      // Reset mid-BUSY (req0 leaves rr pointing at req1 before the reset).
      issue(0, 1, 3'd3, 2'd2, 5'd30, 32'h9999_000A);
      repeat (4) @(negedge clk_i);
      #2;
      chk("busy_before_reset", 64'(gnt_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_gnt", 64'(gnt_o), 64'd0);
      chk("midrst_vrf_req", 64'(vrf_req_o), 64'd0);
      chk("midrst_done", 64'(done_o), 64'd0);
      req_i  = '0;
      rem[0] = 0;
      rem[1] = 0;
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      issue(0, 1, 3'd0, 2'd1, 5'd2, 32'hAAAA_000B);
      issue(1, 1, 3'd0, 2'd1, 5'd6, 32'hBBBB_000C);
      expect_op(0);
      expect_op(1);
      run_ops("post_reset_rr_timeout");

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
